// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU control codes, funct constants and FSM encoding (MUL state only with MULTU_EN)
package alu_pkg;

  localparam logic [3:0] CTRL_AND     = 4'b0000;
  localparam logic [3:0] CTRL_OR      = 4'b0001;
  localparam logic [3:0] CTRL_ADD     = 4'b0010;
  localparam logic [3:0] CTRL_SUB     = 4'b0110;
  localparam logic [3:0] CTRL_SLT     = 4'b0111;
  localparam logic [3:0] CTRL_MULTU   = 4'b1000;
  localparam logic [3:0] CTRL_ILLEGAL = 4'b1111;

  localparam logic [1:0] ALUOP_MEM   = 2'b00;
  localparam logic [1:0] ALUOP_BEQ   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  localparam logic [5:0] FUNCT_ADD   = 6'b100000;
  localparam logic [5:0] FUNCT_SUB   = 6'b100010;
  localparam logic [5:0] FUNCT_AND   = 6'b100100;
  localparam logic [5:0] FUNCT_OR    = 6'b100101;
  localparam logic [5:0] FUNCT_SLT   = 6'b101010;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;

`ifdef MULTU_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DONE = 2'd2
  } state_t;
`endif

endpackage

// File: rtl/alu_ctrl_dec.sv
// rtl/alu_ctrl_dec.sv - combinational ALU control decoder (multu decoded only with MULTU_EN)
module alu_ctrl_dec
  import alu_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] ctrl
);

  always_comb begin
    ctrl = CTRL_ILLEGAL;
    case (alu_op)
      ALUOP_MEM: ctrl = CTRL_ADD;
      ALUOP_BEQ: ctrl = CTRL_SUB;
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_ADD:   ctrl = CTRL_ADD;
          FUNCT_SUB:   ctrl = CTRL_SUB;
          FUNCT_AND:   ctrl = CTRL_AND;
          FUNCT_OR:    ctrl = CTRL_OR;
          FUNCT_SLT:   ctrl = CTRL_SLT;
`ifdef MULTU_EN
          FUNCT_MULTU: ctrl = CTRL_MULTU;
`endif
          default:     ctrl = CTRL_ILLEGAL;
        endcase
      end
      default: ctrl = CTRL_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - registered ALU execute unit with valid/ready handshake
// Optional shift-add unsigned multiply enabled by defining MULTU_EN.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             illegal
);

  logic [3:0]       ctrl;
  logic [WIDTH-1:0] alu_res;
  logic             accept;
  state_t           state;
  state_t           state_nxt;

  alu_ctrl_dec u_dec (
    .alu_op (alu_op),
    .funct  (funct),
    .ctrl   (ctrl)
  );

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign accept    = in_valid && in_ready;

  always_comb begin
    alu_res = '0;
    case (ctrl)
      CTRL_AND: alu_res = src_a & src_b;
      CTRL_OR:  alu_res = src_a | src_b;
      CTRL_ADD: alu_res = src_a + src_b;
      CTRL_SUB: alu_res = src_a - src_b;
      CTRL_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      default:  alu_res = '0;
    endcase
  end

`ifdef MULTU_EN
  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH:0]   mul_sum;
  logic             mul_last;

  // During MUL the output registers double as the {acc, multiplier} shift pair.
  assign mul_sum  = {1'b0, result_hi} + (result[0] ? {1'b0, mcand} : '0);
  assign mul_last = (cnt == CNT_W'(WIDTH - 1));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
`ifdef MULTU_EN
          state_nxt = (ctrl == CTRL_MULTU) ? ST_MUL : ST_DONE;
`else
          state_nxt = ST_DONE;
`endif
        end
      end
`ifdef MULTU_EN
      ST_MUL: begin
        if (mul_last) state_nxt = ST_DONE;
      end
`endif
      ST_DONE: begin
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      result_hi <= '0;
      zero      <= 1'b0;
      illegal   <= 1'b0;
`ifdef MULTU_EN
      cnt       <= '0;
      mcand     <= '0;
`endif
    end else if (accept) begin
      result    <= alu_res;
      result_hi <= '0;
      zero      <= (alu_res == '0);
      illegal   <= (ctrl == CTRL_ILLEGAL);
`ifdef MULTU_EN
      if (ctrl == CTRL_MULTU) begin
        mcand  <= src_a;
        result <= src_b;
        cnt    <= '0;
      end
`endif
    end
`ifdef MULTU_EN
    else if (state == ST_MUL) begin
      {result_hi, result} <= {mul_sum, result[WIDTH-1:1]};
      cnt <= cnt + 1'b1;
      if (mul_last) zero <= ({mul_sum[0], result[WIDTH-1:1]} == '0);
    end
`endif
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - directed scoreboard bench for alu_exec_unit (multiply checks with MULTU_EN)
module tb_alu_exec_unit;

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] hi;
    logic        z;
    logic        ill;
    logic        mul;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [31:0] result_hi;
  logic        zero;
  logic        illegal;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .funct     (funct),
    .src_a     (src_a),
    .src_b     (src_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_hi (result_hi),
    .zero      (zero),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic exp_t model(input logic [1:0] op, input logic [5:0] f,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [63:0] prod;
    e = '0;
    prod = '0;
    case (op)
      2'b00: e.res = a + b;
      2'b01: e.res = a - b;
      2'b10: begin
        case (f)
          6'h20: e.res = a + b;
          6'h22: e.res = a - b;
          6'h24: e.res = a & b;
          6'h25: e.res = a | b;
          6'h2a: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          6'h19: begin
`ifdef MULTU_EN
            prod  = {32'd0, a} * {32'd0, b};
            e.res = prod[31:0];
            e.hi  = prod[63:32];
            e.mul = 1'b1;
`else
            e.ill = 1'b1;
`endif
          end
          default: e.ill = 1'b1;
        endcase
      end
      default: e.ill = 1'b1;
    endcase
    e.z = (e.res == 32'd0);
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one request until accepted, then scrambles the inputs to prove capture.
  task automatic send(input logic [1:0] op, input logic [5:0] f,
                      input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   n;
    e = model(op, f, a, b);
    sb_q.push_back(e);
    alu_op = op; funct = f; src_a = a; src_b = b; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      step(1);
      n++;
    end
    check("accept_ready", {63'd0, in_ready}, 64'd1);
    step(1);
    in_valid = 1'b0;
    alu_op = 2'($urandom); funct = 6'($urandom);
    src_a = $urandom; src_b = $urandom;
    if (!e.mul) check("latency1_out_valid", {63'd0, out_valid}, 64'd1);
  endtask

  task automatic recv(input string tag);
    exp_t e;
    int   n;
    n = 0;
    while (!out_valid && n < 200) begin
      step(1);
      n++;
    end
    check({tag, "_out_valid"}, {63'd0, out_valid}, 64'd1);
    if (sb_q.size() == 0) begin
      check({tag, "_sb_nonempty"}, 64'd0, 64'd1);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_result"},    {32'd0, result},    {32'd0, e.res});
      check({tag, "_result_hi"}, {32'd0, result_hi}, {32'd0, e.hi});
      check({tag, "_zero"},      {63'd0, zero},      {63'd0, e.z});
      check({tag, "_illegal"},   {63'd0, illegal},   {63'd0, e.ill});
    end
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    check({tag, "_in_ready_after"}, {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    exp_t      e;
    int        cnt;
    logic      ready_seen;
    logic [5:0] fn_tab [5];
    fn_tab[0] = 6'h20; fn_tab[1] = 6'h22; fn_tab[2] = 6'h24;
    fn_tab[3] = 6'h25; fn_tab[4] = 6'h2a;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    alu_op = '0; funct = '0; src_a = '0; src_b = '0;
    step(3);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_result",    {32'd0, result},    64'd0);
    check("rst_result_hi", {32'd0, result_hi}, 64'd0);
    check("rst_zero",      {63'd0, zero},      64'd0);
    check("rst_illegal",   {63'd0, illegal},   64'd0);
    rst_n = 1'b1;
    step(1);
    check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

    send(2'b10, 6'h20, 32'h7FFFFFFF, 32'h1);        recv("add_ovf");
    send(2'b10, 6'h2a, 32'hFFFFFFFF, 32'h1);        recv("slt_neg");
    send(2'b10, 6'h2a, 32'h1, 32'hFFFFFFFF);        recv("slt_pos");
    send(2'b01, 6'h3f, 32'h1234, 32'h1234);         recv("beq_eq");
    send(2'b11, 6'h20, 32'h5, 32'h6);               recv("ill_op11");
    send(2'b00, 6'h2a, 32'h10, 32'h20);             recv("ldst_add");
    send(2'b10, 6'h22, 32'h5, 32'h7);               recv("sub_wrap");
    send(2'b10, 6'h21, 32'h5, 32'h7);               recv("ill_funct");
    for (int i = 0; i < 6; i++) begin
      send(2'b10, fn_tab[$urandom_range(0, 4)], $urandom, $urandom);
      recv("rand_rtype");
    end

    // Output must stay frozen while the consumer stalls.
    send(2'b10, 6'h25, 32'hA5A50000, 32'h00005A5A);
    e = sb_q[0];
    for (int i = 0; i < 5; i++) begin
      check("hold_out_valid", {63'd0, out_valid}, 64'd1);
      check("hold_in_ready",  {63'd0, in_ready},  64'd0);
      check("hold_result",    {32'd0, result},    {32'd0, e.res});
      check("hold_zero",      {63'd0, zero},      {63'd0, e.z});
      step(1);
    end
    recv("hold_or");

`ifdef MULTU_EN
    send(2'b10, 6'h19, 32'hFFFFFFFF, 32'h2);
    cnt = 0;
    ready_seen = 1'b0;
    while (!out_valid && cnt < 200) begin
      if (in_ready) ready_seen = 1'b1;
      cnt++;
      step(1);
    end
    check("mul_busy_cycles", 64'(cnt), 64'd32);
    check("mul_ready_seen",  {63'd0, ready_seen}, 64'd0);
    recv("mul_ffff_x2");
    send(2'b10, 6'h19, 32'h0, 32'h1234);            recv("mul_zero");

    send(2'b10, 6'h19, 32'h5, 32'h3);
    step(9);
`else
    send(2'b10, 6'h22, 32'h9, 32'h4);
    step(2);
`endif
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_result",    {32'd0, result},    64'd0);
    check("midrst_result_hi", {32'd0, result_hi}, 64'd0);
    void'(sb_q.pop_back());
    step(2);
    rst_n = 1'b1;
    step(1);
    check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    for (int i = 0; i < 40; i++) begin
      if (out_valid) check("midrst_stale_out_valid", {63'd0, out_valid}, 64'd0);
      step(1);
    end
    send(2'b10, 6'h20, 32'h3, 32'h4);               recv("add_after_rst");

    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
